rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux_pkg.sv | 24 ++
 rtl/rr_arb_mux_if.sv | 36 +++
 rtl/rr_arb_mux_pick.sv | 28 ++
 rtl/rr_arb_mux.sv | 120 ++++++++++++
 tb/tb_rr_arb_mux.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared types for the round-robin arbiter/mux: request and forwarded packet
// layouts plus the arbiter state encoding.
package arb_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
  } packet_in;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  id;
  } packet_out;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb_mux_if.sv
// Bus bundle between the requesting masters, the arbiter and the memory side.
// The arbiter uses the slave modport, the master side drives requests and responses.
interface arb_intf #(
  parameter int N_MASTERS = 4,
  parameter int DATA_W    = 32
);
  import arb_pkg::*;

  localparam int ID_W = $clog2(N_MASTERS);

  logic [N_MASTERS-1:0] REQ;
  logic [N_MASTERS-1:0] MASK;
  logic [N_MASTERS-1:0] GNT;
  packet_in [N_MASTERS-1:0] master_in_data;
  packet_out            master_out_data;
  logic                 mem_valid;
  logic [DATA_W-1:0]    rdata;
  logic                 rdata_ack;
  logic [DATA_W-1:0]    slave_rdata;
  logic                 slave_rdata_ack;
  logic [ID_W-1:0]      slave_id;
  logic                 timeout_err;

  modport slave (
    input  REQ, MASK, master_in_data, rdata, rdata_ack,
    output GNT, master_out_data, mem_valid, slave_rdata, slave_rdata_ack,
           slave_id, timeout_err
  );

  modport master (
    output REQ, MASK, master_in_data, rdata, rdata_ack,
    input  GNT, master_out_data, mem_valid, slave_rdata, slave_rdata_ack,
           slave_id, timeout_err
  );

endinterface

// File: rtl/rr_arb_mux_pick.sv
// Combinational round-robin picker: first set bit of the eligible vector at
// or after ptr, searching modulo N_MASTERS.
module rr_pick #(
  parameter int N_MASTERS = 4,
  parameter int ID_W      = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] eligible,
  input  logic [ID_W-1:0]      ptr,
  output logic [ID_W-1:0]      winner,
  output logic                 valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      idx = ID_W'((int'(ptr) + i) % N_MASTERS);
      if (!valid && eligible[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbiter that forwards one master's packet to memory at a time
// and routes the memory response back, with a forced release on timeout.
module rr_arb_mux #(
  parameter int N_MASTERS = 4,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255
) (
  input logic    clk,
  input logic    reset,
  arb_intf.slave bus
);
  import arb_pkg::*;

  localparam int ID_W = $clog2(N_MASTERS);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_ISSUE = 2'(ISSUE);
  localparam logic [1:0] ST_WAIT  = 2'(WAIT);

  // The counter starts at zero on WAIT entry, so the last waiting cycle is TIMEOUT-1.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]           state;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      owner;
  logic [ID_W-1:0]      owner_next;
  logic [15:0]          wait_cnt;
  logic [N_MASTERS-1:0] eligible;
  logic [ID_W-1:0]      winner;
  logic                 win_valid;
  packet_in             sel_pkt;

  logic [N_MASTERS-1:0] gnt_q;
  packet_out            out_q;
  logic                 mem_valid_q;
  logic [DATA_W-1:0]    slave_rdata_q;
  logic                 slave_ack_q;
  logic [ID_W-1:0]      slave_id_q;
  logic                 timeout_q;

  assign eligible   = bus.REQ & ~bus.MASK;
  assign sel_pkt    = bus.master_in_data[winner];
  assign owner_next = (int'(owner) == N_MASTERS - 1) ? '0 : owner + 1'b1;

  rr_pick #(
    .N_MASTERS(N_MASTERS),
    .ID_W     (ID_W)
  ) u_pick (
    .eligible(eligible),
    .ptr     (ptr),
    .winner  (winner),
    .valid   (win_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      owner         <= '0;
      wait_cnt      <= '0;
      gnt_q         <= '0;
      out_q         <= '0;
      mem_valid_q   <= 1'b0;
      slave_rdata_q <= '0;
      slave_ack_q   <= 1'b0;
      slave_id_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      mem_valid_q <= 1'b0;
      slave_ack_q <= 1'b0;
      timeout_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state       <= ST_ISSUE;
            owner       <= winner;
            gnt_q       <= {{(N_MASTERS-1){1'b0}}, 1'b1} << winner;
            out_q.addr  <= sel_pkt.addr;
            out_q.wdata <= sel_pkt.wdata;
            out_q.wr    <= sel_pkt.wr;
            out_q.id    <= 4'(winner);
          end
        end
        ST_ISSUE: begin
          mem_valid_q <= 1'b1;
          wait_cnt    <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          // An ack on the final counted cycle still completes normally.
          if (bus.rdata_ack) begin
            slave_rdata_q <= bus.rdata;
            slave_ack_q   <= 1'b1;
            slave_id_q    <= owner;
            gnt_q         <= '0;
            ptr           <= owner_next;
            state         <= ST_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_q <= 1'b1;
            gnt_q     <= '0;
            ptr       <= owner_next;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.GNT             = gnt_q;
  assign bus.master_out_data = out_q;
  assign bus.mem_valid       = mem_valid_q;
  assign bus.slave_rdata     = slave_rdata_q;
  assign bus.slave_rdata_ack = slave_ack_q;
  assign bus.slave_id        = slave_id_q;
  assign bus.timeout_err     = timeout_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios plus randomized
// transactions compared against a transaction-level round-robin model.
module tb_rr_arb_mux;
  import arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  // Model state: next-priority master and last delivered response word.
  int          m_ptr;
  logic [31:0] m_rdata;
  packet_in    pkts [N];

  arb_intf #(.N_MASTERS(N), .DATA_W(DW)) bus ();

  rr_arb_mux #(
    .N_MASTERS(N),
    .DATA_W   (DW),
    .TIMEOUT  (TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Winner is the eligible master with the smallest forward distance from ptr.
  function automatic int model_winner(logic [N-1:0] req, logic [N-1:0] mask, int ptr);
    int best   = -1;
    int best_d = N;
    for (int m = 0; m < N; m++) begin
      if (req[m] && !mask[m]) begin
        int d;
        d = (m - ptr + N) % N;
        if (d < best_d) begin
          best_d = d;
          best   = m;
        end
      end
    end
    return best;
  endfunction

  task automatic load_packets();
    for (int m = 0; m < N; m++) begin
      pkts[m].addr  = $urandom;
      pkts[m].wdata = $urandom;
      pkts[m].wr    = 1'($urandom_range(0, 1));
      bus.master_in_data[m] = pkts[m];
    end
  endtask

  // One arbitration from an IDLE cycle; ack_after counts WAIT cycles, >= TO means no ack.
  task automatic run_txn(input logic [N-1:0] req, input logic [N-1:0] mask,
                         input int ack_after, input logic [31:0] resp,
                         input bit ack_in_issue, input string tag);
    int           w;
    logic [N-1:0] exp_gnt;
    packet_out    exp_out;
    load_packets();
    bus.REQ       = req;
    bus.MASK      = mask;
    bus.rdata_ack = 1'b0;
    w = model_winner(req, mask, m_ptr);
    step();
    if (w < 0) begin
      checks++;
      if (bus.GNT !== '0) begin
        failures++;
        $display("FAIL %s idle_gnt: got %b want %b", tag, bus.GNT, {N{1'b0}});
      end
      return;
    end
    exp_gnt       = N'(1) << w;
    exp_out.addr  = pkts[w].addr;
    exp_out.wdata = pkts[w].wdata;
    exp_out.wr    = pkts[w].wr;
    exp_out.id    = 4'(w);
    checks++;
    if (bus.GNT !== exp_gnt) begin
      failures++;
      $display("FAIL %s gnt: got %b want %b", tag, bus.GNT, exp_gnt);
    end
    // Owner may drop or be masked now; inputs scrambled to show the grant is held.
    bus.REQ  = N'($urandom);
    bus.MASK = N'($urandom);
    load_packets();
    if (ack_in_issue) begin
      bus.rdata_ack = 1'b1;
      bus.rdata     = $urandom;
    end
    step();
    bus.rdata_ack = 1'b0;
    checks++;
    if (bus.mem_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s mem_valid: got %b want 1", tag, bus.mem_valid);
    end
    checks++;
    if (bus.master_out_data !== exp_out) begin
      failures++;
      $display("FAIL %s out_data: got %h want %h", tag, bus.master_out_data, exp_out);
    end
    checks++;
    if (bus.slave_rdata_ack !== 1'b0) begin
      failures++;
      $display("FAIL %s issue_ack: got %b want 0", tag, bus.slave_rdata_ack);
    end
    for (int k = 0; k < TO; k++) begin
      if (k == ack_after) begin
        bus.rdata_ack = 1'b1;
        bus.rdata     = resp;
      end
      step();
      bus.rdata_ack = 1'b0;
      if (k == ack_after) begin
        checks++;
        if (bus.slave_rdata_ack !== 1'b1 || bus.slave_rdata !== resp ||
            bus.slave_id !== 2'(w)) begin
          failures++;
          $display("FAIL %s resp: got ack=%b data=%h id=%0d want ack=1 data=%h id=%0d",
                   tag, bus.slave_rdata_ack, bus.slave_rdata, bus.slave_id, resp, w);
        end
        checks++;
        if (bus.GNT !== '0 || bus.timeout_err !== 1'b0) begin
          failures++;
          $display("FAIL %s release: got gnt=%b tmo=%b want gnt=0 tmo=0",
                   tag, bus.GNT, bus.timeout_err);
        end
        m_rdata = resp;
        m_ptr   = (w + 1) % N;
        return;
      end else if (k == TO - 1) begin
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.GNT !== '0 || bus.slave_rdata_ack !== 1'b0) begin
          failures++;
          $display("FAIL %s timeout: got tmo=%b gnt=%b ack=%b want tmo=1 gnt=0 ack=0",
                   tag, bus.timeout_err, bus.GNT, bus.slave_rdata_ack);
        end
        checks++;
        if (bus.slave_rdata !== m_rdata) begin
          failures++;
          $display("FAIL %s rdata_hold: got %h want %h", tag, bus.slave_rdata, m_rdata);
        end
        m_ptr = (w + 1) % N;
        return;
      end else begin
        checks++;
        if (bus.GNT !== exp_gnt || bus.mem_valid !== 1'b0 || bus.timeout_err !== 1'b0) begin
          failures++;
          $display("FAIL %s wait: got gnt=%b mv=%b tmo=%b want gnt=%b mv=0 tmo=0",
                   tag, bus.GNT, bus.mem_valid, bus.timeout_err, exp_gnt);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (bus.GNT !== '0 || bus.mem_valid !== 1'b0 || bus.master_out_data !== '0 ||
        bus.slave_rdata !== '0 || bus.slave_rdata_ack !== 1'b0 ||
        bus.slave_id !== '0 || bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL %s zero: got gnt=%b mv=%b out=%h rd=%h ack=%b id=%0d tmo=%b want all 0",
               tag, bus.GNT, bus.mem_valid, bus.master_out_data, bus.slave_rdata,
               bus.slave_rdata_ack, bus.slave_id, bus.timeout_err);
    end
  endtask

  task automatic test_reset();
    reset              = 1'b1;
    bus.REQ            = '0;
    bus.MASK           = '0;
    bus.rdata_ack      = 1'b0;
    bus.rdata          = '0;
    bus.master_in_data = '0;
    repeat (2) step();
    check_all_zero("reset");
    reset   = 1'b0;
    m_ptr   = 0;
    m_rdata = '0;
  endtask

  task automatic test_rotation();
    for (int i = 0; i < 5; i++) run_txn(4'b1111, 4'b0000, 2, $urandom, 1'b0, "rotation");
  endtask

  task automatic test_mask();
    for (int i = 0; i < 4; i++)
      run_txn(4'b0101, 4'b0001, $urandom_range(0, 3), $urandom, 1'b0, "mask");
  endtask

  task automatic test_response();
    run_txn(4'b0010, 4'b0000, 0, 32'hDEADBEEF, 1'b0, "response");
  endtask

  task automatic test_timeout();
    run_txn(4'b0100, 4'b0000, TO, 32'h0, 1'b0, "timeout");
    run_txn(4'b1100, 4'b0000, 1, $urandom, 1'b0, "after_timeout");
    run_txn(4'b0001, 4'b0000, TO - 1, $urandom, 1'b0, "ack_at_limit");
  endtask

  task automatic test_idle_ack();
    bus.REQ       = '0;
    bus.rdata_ack = 1'b1;
    bus.rdata     = $urandom;
    step();
    bus.rdata_ack = 1'b0;
    checks++;
    if (bus.slave_rdata_ack !== 1'b0 || bus.slave_rdata !== m_rdata ||
        bus.GNT !== '0 || bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack: got ack=%b rd=%h gnt=%b tmo=%b want ack=0 rd=%h gnt=0 tmo=0",
               bus.slave_rdata_ack, bus.slave_rdata, bus.GNT, bus.timeout_err, m_rdata);
    end
    run_txn(4'b0001, 4'b0000, 0, $urandom, 1'b0, "after_idle_ack");
  endtask

  task automatic test_reset_mid();
    load_packets();
    bus.REQ  = 4'b1000;
    bus.MASK = '0;
    step();
    checks++;
    if (bus.GNT !== 4'b1000) begin
      failures++;
      $display("FAIL rst_mid gnt: got %b want 1000", bus.GNT);
    end
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    bus.rdata_ack = 1'b1;
    bus.rdata     = $urandom;
    step();
    step();
    check_all_zero("rst_hold");
    reset   = 1'b0;
    m_ptr   = 0;
    m_rdata = '0;
    run_txn(4'b1000, 4'b0000, 1, $urandom, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_txn(N'($urandom), N'($urandom & $urandom), $urandom_range(0, 9), $urandom,
              1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_mask();
    test_response();
    test_timeout();
    test_idle_ack();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
